// File: rtl/dsm_interp_feeder.sv
// dsm_interp_feeder: conditions sparse Q16.16 Lorenz samples into the DAC's
// signed word and produces one new DAC input per clock between samples.
// Build option DSM_INTERP_LINEAR_EN: defined gives linear interpolation between
// samples; undefined gives a zero-order hold with identical handshake, segment
// timing, seg_start and underrun behaviour.
module dsm_interp_feeder #(
   parameter int IN_W        = 32,
   parameter int SHIFT       = 8,
   parameter int OUT_W       = 16,
   parameter int INTERP_LOG2 = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] dout,
   output logic             seg_start,
   output logic             sat_pulse,
   output logic             underrun,
   input  logic             clr_underrun
);

   localparam int ACC_W = OUT_W + INTERP_LOG2;
   localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 <<< (OUT_W - 1)) - 1);
   localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [INTERP_LOG2-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {IDLE, RAMP, STALL} state_t;

   state_t                  state;
   logic signed [OUT_W-1:0] pend;
   logic                    pend_valid;
   logic signed [OUT_W-1:0] target;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] step;
   logic signed [ACC_W-1:0] load_acc;
   logic signed [OUT_W:0]   diff;
   logic [INTERP_LOG2-1:0]  cnt;
   logic [OUT_W:0]          cond;
   logic                    accept;
   logic                    seg_last;
   logic                    do_load;

   // Arithmetic shift then clip to the DAC range; MSB of the result flags clipping.
   function automatic logic [OUT_W:0] sat_shift(input logic signed [IN_W-1:0] x);
      logic signed [IN_W-1:0] s;
      s = x >>> SHIFT;
      if (s > SAT_MAX)
         return {1'b1, SAT_MAX[OUT_W-1:0]};
      else if (s < SAT_MIN)
         return {1'b1, SAT_MIN[OUT_W-1:0]};
      else
         return {1'b0, s[OUT_W-1:0]};
   endfunction

   assign cond     = sat_shift($signed(in_data));
   assign in_ready = ~pend_valid;
   assign accept   = in_valid & ~pend_valid;
   assign seg_last = (cnt == CNT_LAST);
   // A load happens from IDLE/STALL as soon as a sample waits, or on the last ramp edge.
   assign do_load  = pend_valid & ((state != RAMP) | seg_last);
   assign dout     = acc[ACC_W-1:INTERP_LOG2];
   assign step     = ACC_W'(diff);

`ifdef DSM_INTERP_LINEAR_EN
   logic signed [OUT_W-1:0] base;

   // Segment start point: the outgoing target (0 out of reset) latched on every load.
   always_ff @(posedge clk) begin
      if (rst)
         base <= '0;
      else if (do_load)
         base <= target;
   end

   // One extra bit keeps the difference of two full-range words exact.
   assign diff     = {target[OUT_W-1], target} - {base[OUT_W-1], base};
   assign load_acc = {target, {INTERP_LOG2{1'b0}}};
`else
   assign diff     = '0;
   assign load_acc = {pend, {INTERP_LOG2{1'b0}}};
`endif

   // Handshake, segment FSM, accumulator and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pend       <= '0;
         pend_valid <= 1'b0;
         target     <= '0;
         acc        <= '0;
         cnt        <= '0;
         seg_start  <= 1'b0;
         sat_pulse  <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         seg_start <= 1'b0;
         sat_pulse <= accept & cond[OUT_W];
         if (accept) begin
            pend       <= cond[OUT_W-1:0];
            pend_valid <= 1'b1;
         end
         if (clr_underrun)
            underrun <= 1'b0;
         if (do_load) begin
            target     <= pend;
            acc        <= load_acc;
            cnt        <= '0;
            pend_valid <= 1'b0;
            seg_start  <= 1'b1;
            state      <= RAMP;
         end else if (state == RAMP) begin
            if (seg_last) begin
               // Snap to the exact target so rounding never drifts into the hold value.
               acc      <= {target, {INTERP_LOG2{1'b0}}};
               underrun <= 1'b1;
               state    <= STALL;
            end else begin
               acc <= acc + step;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dsm_interp_feeder.sv
// Directed bench for dsm_interp_feeder with INTERP_LOG2=2, SHIFT=8.
// Expected values follow the build: linear ramps when DSM_INTERP_LINEAR_EN is
// defined, zero-order hold otherwise.
module tb_dsm_interp_feeder;

   localparam int IN_W  = 32;
   localparam int SHIFT = 8;
   localparam int OUT_W = 16;
   localparam int L2    = 2;
`ifdef DSM_INTERP_LINEAR_EN
   localparam bit LIN = 1'b1;
`else
   localparam bit LIN = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic [IN_W-1:0]         in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [OUT_W-1:0] dout;
   logic                    seg_start;
   logic                    sat_pulse;
   logic                    underrun;
   logic                    clr_underrun;
   int                      tests = 0;
   int                      fails = 0;

   always #5 clk = ~clk;

   dsm_interp_feeder #(
      .IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .INTERP_LOG2(L2)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .dout(dout), .seg_start(seg_start),
      .sat_pulse(sat_pulse), .underrun(underrun), .clr_underrun(clr_underrun)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; in_valid = 1'b0; clr_underrun = 1'b0; in_data = '0;
      tick; tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      tests++; if (dout !== 16'sd0) begin fails++; $display("FAIL reset_dout: got %0d, expected 0", dout); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
      tests++; if (seg_start !== 1'b0) begin fails++; $display("FAIL reset_seg_start: got %b, expected 0", seg_start); end
      tests++; if (sat_pulse !== 1'b0) begin fails++; $display("FAIL reset_sat_pulse: got %b, expected 0", sat_pulse); end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b, expected 0", underrun); end
      repeat (6) tick;
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL idle_underrun: got %b, expected 0", underrun); end
      tests++; if (dout !== 16'sd0) begin fails++; $display("FAIL idle_dout: got %0d, expected 0", dout); end
   endtask

   task automatic test_linear_ramp;
      int e;
      int nseg;
      do_reset;
      in_data = 32'h0000_4000; in_valid = 1'b1;
      tick;                                  // accept
      in_valid = 1'b0;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ramp_accept_ready: got %b, expected 0", in_ready); end
      tests++; if (sat_pulse !== 1'b0) begin fails++; $display("FAIL ramp_no_clip: got %b, expected 0", sat_pulse); end
      tests++; if (dout !== 16'sd0) begin fails++; $display("FAIL ramp_accept_dout: got %0d, expected 0", dout); end
      tick;                                  // load
      e = LIN ? 0 : 64;
      tests++; if (seg_start !== 1'b1) begin fails++; $display("FAIL ramp_seg_start: got %b, expected 1", seg_start); end
      tests++; if (dout !== 16'(e)) begin fails++; $display("FAIL ramp_load_dout: got %0d, expected %0d", dout, e); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ramp_ready_after_load: got %b, expected 1", in_ready); end
      nseg = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         nseg += int'(seg_start);
         e = LIN ? 16 * (i + 1) : 64;
         tests++; if (dout !== 16'(e)) begin fails++; $display("FAIL ramp_dout[%0d]: got %0d, expected %0d", i, dout, e); end
      end
      tests++; if (nseg !== 0) begin fails++; $display("FAIL ramp_extra_seg_start: got %0d, expected 0", nseg); end
   endtask

   task automatic test_clip;
      logic [31:0] cv[5] = '{32'h0100_0000, 32'hFF00_0000, 32'h007F_FF00, 32'hFF80_0000, 32'hFFFF_FFFF};
      bit          cs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int          ce[5] = '{32767, -32768, 32767, -32768, -1};
      for (int v = 0; v < 5; v++) begin
         do_reset;
         in_data = cv[v]; in_valid = 1'b1;
         tick;                               // accept
         in_valid = 1'b0;
         tests++; if (sat_pulse !== cs[v]) begin fails++; $display("FAIL clip_pulse[%0d]: got %b, expected %b", v, sat_pulse, cs[v]); end
         tick;                               // load
         tests++; if (sat_pulse !== 1'b0) begin fails++; $display("FAIL clip_pulse_len[%0d]: got %b, expected 0", v, sat_pulse); end
         repeat (4) tick;
         tests++; if (dout !== 16'(ce[v])) begin fails++; $display("FAIL clip_value[%0d]: got %0d, expected %0d", v, dout, ce[v]); end
      end
   endtask

   task automatic test_back_to_back;
      int e;
      int e2[3];
      do_reset;
      in_data = 32'h0000_4000; in_valid = 1'b1;
      tick;                                  // accept 64
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_full: got %b, expected 0", in_ready); end
      in_data = 32'hFFFF_C000;
      tick;                                  // load 64, no accept (pend full)
      e = LIN ? 0 : 64;
      tests++; if (seg_start !== 1'b1) begin fails++; $display("FAIL b2b_seg1: got %b, expected 1", seg_start); end
      tests++; if (dout !== 16'(e)) begin fails++; $display("FAIL b2b_load1_dout: got %0d, expected %0d", dout, e); end
      tick;                                  // accept -64
      in_valid = 1'b0;
      e = LIN ? 16 : 64;
      tests++; if (dout !== 16'(e)) begin fails++; $display("FAIL b2b_ramp1_dout: got %0d, expected %0d", dout, e); end
      tick; tick;
      tests++; if (seg_start !== 1'b0) begin fails++; $display("FAIL b2b_early_seg: got %b, expected 0", seg_start); end
      tick;                                  // second load
      e = LIN ? 64 : -64;
      tests++; if (seg_start !== 1'b1) begin fails++; $display("FAIL b2b_seg2: got %b, expected 1", seg_start); end
      tests++; if (dout !== 16'(e)) begin fails++; $display("FAIL b2b_load2_dout: got %0d, expected %0d", dout, e); end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL b2b_underrun: got %b, expected 0", underrun); end
      e2 = LIN ? '{32, 0, -32} : '{-64, -64, -64};
      for (int i = 0; i < 3; i++) begin
         tick;
         tests++; if (dout !== 16'(e2[i])) begin fails++; $display("FAIL b2b_ramp2_dout[%0d]: got %0d, expected %0d", i, dout, e2[i]); end
      end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL b2b_underrun_end: got %b, expected 0", underrun); end
      tick;
      tests++; if (dout !== -16'sd64) begin fails++; $display("FAIL b2b_final_dout: got %0d, expected -64", dout); end
   endtask

   task automatic test_backpressure;
      logic [31:0] vals[4] = '{32'h0000_4000, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_C000};
      logic [13:0] rdy_seen;
      logic [13:0] rdy_exp;
      logic        acc_now;
      int          idx, n_acc, n_seg, d5, d7, d9, d13, e;
      do_reset;
      idx = 0; n_acc = 0; n_seg = 0; d5 = 0; d7 = 0; d9 = 0; d13 = 0;
      rdy_seen = '0;
      rdy_exp  = 14'b10001000100010;
      in_data = vals[0]; in_valid = 1'b1;
      for (int i = 0; i < 14; i++) begin
         acc_now = in_valid & in_ready;
         tick;
         rdy_seen[i] = in_ready;
         n_seg += int'(seg_start);
         if (i == 5)  d5  = int'(dout);
         if (i == 7)  d7  = int'(dout);
         if (i == 9)  d9  = int'(dout);
         if (i == 13) d13 = int'(dout);
         if (acc_now) begin
            n_acc++; idx++;
            if (idx == 4) in_valid = 1'b0;
            else in_data = vals[idx];
         end
      end
      tests++; if (rdy_seen !== rdy_exp) begin fails++; $display("FAIL bp_ready_pattern: got %b, expected %b", rdy_seen, rdy_exp); end
      tests++; if (n_acc !== 4) begin fails++; $display("FAIL bp_accepts: got %0d, expected 4", n_acc); end
      tests++; if (n_seg !== 4) begin fails++; $display("FAIL bp_segments: got %0d, expected 4", n_seg); end
      e = LIN ? 64 : 128;
      tests++; if (d5 !== e) begin fails++; $display("FAIL bp_dout_e5: got %0d, expected %0d", d5, e); end
      e = LIN ? 96 : 128;
      tests++; if (d7 !== e) begin fails++; $display("FAIL bp_dout_e7: got %0d, expected %0d", d7, e); end
      e = LIN ? 128 : 0;
      tests++; if (d9 !== e) begin fails++; $display("FAIL bp_dout_e9: got %0d, expected %0d", d9, e); end
      e = LIN ? 0 : -64;
      tests++; if (d13 !== e) begin fails++; $display("FAIL bp_dout_e13: got %0d, expected %0d", d13, e); end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL bp_underrun: got %b, expected 0", underrun); end
   endtask

   task automatic test_underrun;
      int e;
      int er[4];
      do_reset;
      in_data = 32'h0000_4000; in_valid = 1'b1;
      tick; in_valid = 1'b0;
      tick;                                  // load
      repeat (3) tick;
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ur_before_end: got %b, expected 0", underrun); end
      tick;                                  // segment end, nothing pending
      tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_set: got %b, expected 1", underrun); end
      tests++; if (dout !== 16'sd64) begin fails++; $display("FAIL ur_end_dout: got %0d, expected 64", dout); end
      repeat (2) tick;
      tests++; if (dout !== 16'sd64) begin fails++; $display("FAIL ur_hold_dout: got %0d, expected 64", dout); end
      tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_sticky: got %b, expected 1", underrun); end
      in_data = 32'h0000_0000; in_valid = 1'b1;
      tick; in_valid = 1'b0;
      tick;                                  // load from STALL
      e = LIN ? 64 : 0;
      tests++; if (seg_start !== 1'b1) begin fails++; $display("FAIL ur_stall_seg: got %b, expected 1", seg_start); end
      tests++; if (dout !== 16'(e)) begin fails++; $display("FAIL ur_stall_load_dout: got %0d, expected %0d", dout, e); end
      er = LIN ? '{48, 32, 16, 0} : '{0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         tick;
         tests++; if (dout !== 16'(er[i])) begin fails++; $display("FAIL ur_ramp_dout[%0d]: got %0d, expected %0d", i, dout, er[i]); end
      end
      clr_underrun = 1'b1; tick; clr_underrun = 1'b0;
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ur_clear: got %b, expected 0", underrun); end
      in_data = 32'h0000_4000; in_valid = 1'b1;
      tick; in_valid = 1'b0;
      tick;                                  // load
      clr_underrun = 1'b1;
      repeat (3) tick;
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ur_clear_held: got %b, expected 0", underrun); end
      tick;                                  // set and clear on the same edge
      clr_underrun = 1'b0;
      tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_set_wins: got %b, expected 1", underrun); end
   endtask

   task automatic test_reset_mid_ramp;
      int e;
      int nseg;
      do_reset;
      in_data = 32'h0000_4000; in_valid = 1'b1;
      tick; in_valid = 1'b0;
      repeat (5) tick;                       // load then end with underrun
      tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL rm_pre_underrun: got %b, expected 1", underrun); end
      in_data = 32'h0000_8000; in_valid = 1'b1;
      tick;                                  // accept 128
      in_data = 32'h0000_C000;
      tick;                                  // load 128
      tick;                                  // accept 192, cnt = 1
      in_valid = 1'b0;
      e = LIN ? 80 : 128;
      tests++; if (dout !== 16'(e)) begin fails++; $display("FAIL rm_pre_dout: got %0d, expected %0d", dout, e); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rm_pre_ready: got %b, expected 0", in_ready); end
      rst = 1'b1; tick; rst = 1'b0;
      tests++; if (dout !== 16'sd0) begin fails++; $display("FAIL rm_dout: got %0d, expected 0", dout); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rm_ready: got %b, expected 1", in_ready); end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL rm_underrun: got %b, expected 0", underrun); end
      tests++; if (seg_start !== 1'b0) begin fails++; $display("FAIL rm_seg_start: got %b, expected 0", seg_start); end
      nseg = 0;
      repeat (4) begin
         tick;
         nseg += int'(seg_start);
      end
      tests++; if (nseg !== 0) begin fails++; $display("FAIL rm_discard_seg: got %0d, expected 0", nseg); end
      tests++; if (dout !== 16'sd0) begin fails++; $display("FAIL rm_idle_dout: got %0d, expected 0", dout); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_underrun = 1'b0;
      test_reset;
      test_linear_ramp;
      test_clip;
      test_back_to_back;
      test_backpressure;
      test_underrun;
      test_reset_mid_ramp;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
